// File: rtl/pc_seq_pkg.sv
// Shared constants for the pc_seq program-counter sequencer:
// branch opcode encodings and the resolve countdown width.
package pc_seq_pkg;

  localparam int CNT_W = 3;

  localparam logic [2:0] BR_EQ = 3'd0;
  localparam logic [2:0] BR_NE = 3'd1;
  localparam logic [2:0] BR_LT = 3'd2;
  localparam logic [2:0] BR_LE = 3'd3;
  localparam logic [2:0] BR_JR = 3'd4;

endpackage

// File: rtl/pc_seq_npc.sv
// Combinational next-PC selection for a resolving branch/JR.
// Produces the fall-through PC, the chosen PC and whether it is a redirect.
module pc_seq_npc
  import pc_seq_pkg::*;
#(
  parameter int PC_W       = 32,
  parameter int DATA_W     = 32,
  parameter int SIGNED_CMP = 0
) (
  input  logic [2:0]        br_op_i,
  input  logic [DATA_W-1:0] br_os_i,
  input  logic [DATA_W-1:0] br_ot_i,
  input  logic [DATA_W-1:0] br_imm_i,
  input  logic [PC_W-1:0]   ex_pc_i,
  output logic [PC_W-1:0]   nonbranch_o,
  output logic [PC_W-1:0]   npc_o,
  output logic              redirect_o
);

  logic signed [PC_W-1:0] imm_ext;
  logic signed [PC_W-1:0] disp;
  logic [PC_W-1:0]        branch;
  logic                   eq;
  logic                   lt;
  logic                   taken;

  // Byte displacement becomes a word displacement; the shift keeps the sign.
  assign imm_ext     = PC_W'($signed(br_imm_i));
  assign disp        = imm_ext >>> 2;
  assign nonbranch_o = ex_pc_i + 1'b1;
  assign branch      = nonbranch_o + $unsigned(disp);

  assign eq = (br_os_i == br_ot_i);
  assign lt = (SIGNED_CMP != 0) ? ($signed(br_os_i) < $signed(br_ot_i))
                                : (br_os_i < br_ot_i);

  always_comb begin
    taken = 1'b0;
    npc_o = nonbranch_o;
    case (br_op_i)
      BR_EQ:   taken = eq;
      BR_NE:   taken = !eq;
      BR_LT:   taken = lt;
      BR_LE:   taken = lt || eq;
      default: taken = 1'b0;
    endcase
    if (br_op_i == BR_JR) begin
      npc_o = PC_W'(br_os_i);
    end else if (taken) begin
      npc_o = branch;
    end
  end

  // JR always flushes, even when it lands on the fall-through address.
  assign redirect_o = (npc_o != nonbranch_o) || (br_op_i == BR_JR);

endmodule

// File: rtl/pc_seq.sv
// Fetch PC sequencer: sequential advance, jumps, delayed branch resolve, stall, halt.
// Optional perf counters are built when PC_SEQ_PERF_EN is defined.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int PC_W       = 32,
  parameter int DATA_W     = 32,
  parameter int BR_LAT     = 2,
  parameter int SIGNED_CMP = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              jmp_valid,
  input  logic [PC_W+1:0]   jmp_addr,
  input  logic              br_issue,
  input  logic [2:0]        br_op,
  input  logic [DATA_W-1:0] br_os,
  input  logic [DATA_W-1:0] br_ot,
  input  logic [DATA_W-1:0] br_imm,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic              halt_req,
  output logic [PC_W-1:0]   pc_out,
  output logic              redirect,
  output logic              br_pending,
  output logic              halted,
  output logic [31:0]       perf_redirects,
  output logic [31:0]       perf_stalls
);

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             redirect_q, redirect_d;
  logic             halted_q, halted_d;
  logic [PC_W-1:0]  nonbranch;
  logic [PC_W-1:0]  npc;
  logic             br_redirect;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^jmp_addr[1:0];

  pc_seq_npc #(
    .PC_W       (PC_W),
    .DATA_W     (DATA_W),
    .SIGNED_CMP (SIGNED_CMP)
  ) u_npc (
    .br_op_i     (br_op),
    .br_os_i     (br_os),
    .br_ot_i     (br_ot),
    .br_imm_i    (br_imm),
    .ex_pc_i     (ex_pc),
    .nonbranch_o (nonbranch),
    .npc_o       (npc),
    .redirect_o  (br_redirect)
  );

  always_comb begin
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    redirect_d = redirect_q;
    halted_d   = halted_q;
    if (halted_q) begin
      pc_d = pc_q;
    end else if (stall) begin
      redirect_d = 1'b0;
    end else begin
      if (jmp_valid) begin
        pc_d       = jmp_addr[PC_W+1:2];
        redirect_d = 1'b1;
      end else if (cnt_q == CNT_W'(1)) begin
        pc_d       = npc;
        redirect_d = br_redirect;
      end else if (halt_req) begin
        pc_d       = ex_pc;
        halted_d   = 1'b1;
        redirect_d = 1'b0;
      end else begin
        pc_d       = pc_q + 1'b1;
        redirect_d = 1'b0;
      end
      // The countdown runs on its own, whichever PC source won above.
      if (br_issue) begin
        cnt_d = CNT_W'(BR_LAT);
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= '0;
      cnt_q      <= '0;
      redirect_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      redirect_q <= redirect_d;
      halted_q   <= halted_d;
    end
  end

  assign pc_out     = pc_q;
  assign redirect   = redirect_q;
  assign br_pending = (cnt_q != '0);
  assign halted     = halted_q;

`ifdef PC_SEQ_PERF_EN
  logic [31:0] perf_red_q;
  logic [31:0] perf_stall_q;

  // Both counters saturate instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_red_q   <= '0;
      perf_stall_q <= '0;
    end else if (!halted_q) begin
      if (stall && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + 1'b1;
      end
      if (!stall && redirect_d && (perf_red_q != '1)) begin
        perf_red_q <= perf_red_q + 1'b1;
      end
    end
  end

  assign perf_redirects = perf_red_q;
  assign perf_stalls    = perf_stall_q;
`else
  assign perf_redirects = '0;
  assign perf_stalls    = '0;
`endif

endmodule

// File: doc/pc_seq.md
Name: pc_seq

Overview:
- Parametrised program-counter sequencer for the pipelined core; successor to the fixed 32-bit, fixed-2-cycle fetch PC unit.
- Holds the word-addressed fetch PC and handles sequential advance, decode-stage jumps, delayed branch/JR resolution with configurable latency, stall, and halt.
- Emits a redirect pulse so the fetch/decode stages can flush.
- Sits between the fetch stage (consumes pc_out) and the decode/execute stages (drive redirect inputs).

Parameters:
- PC_W, 32, width of the word-addressed PC.
- DATA_W, 32, operand/immediate width.
- BR_LAT, 2, cycles from br_issue to branch resolution; legal range 1..7.
- SIGNED_CMP, 0, 1 makes the LT/LE compares signed; 0 makes them unsigned.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- stall  in  1  freeze all state this cycle.
- jmp_valid  in  1  decode-stage absolute jump.
- jmp_addr  in  PC_W+2  jump byte address.
- br_issue  in  1  branch/JR decoded; starts the resolve countdown.
- br_op  in  3  0 EQ, 1 NE, 2 LT, 3 LE, 4 JR; others give no branch.
- br_os  in  DATA_W  first operand at resolve.
- br_ot  in  DATA_W  second operand at resolve.
- br_imm  in  DATA_W  signed byte displacement.
- ex_pc  in  PC_W  PC of the instruction in the resolve stage.
- halt_req  in  1  halt opcode in the resolve stage.
- pc_out  out  PC_W  current fetch PC.
- redirect  out  1  registered pulse: pc_out was loaded non-sequentially.
- br_pending  out  1  resolve countdown nonzero.
- halted  out  1  sequencer frozen.
- perf_redirects  out  32  perf counter (see Optional Feature).
- perf_stalls  out  32  perf counter (see Optional Feature).

Behaviour:
Reset values: pc_out=0, count=0, redirect=0, halted=0, perf counters=0. The reset is asynchronous, so it takes effect mid-operation at any time.

Update priority each rising edge (the first matching condition acts):
1. halted=1: hold everything. Only rst releases it.
2. stall=1: hold pc and count; redirect<=0; perf_stalls increments.
3. jmp_valid=1: pc<=jmp_addr[PC_W+1:2]; redirect<=1.
4. count==1 (resolve): pc<=npc; redirect<=1 only when npc!=nonbranch, or when br_op=JR.
5. halt_req=1: pc<=ex_pc; halted<=1; redirect<=0.
6. Otherwise: pc<=pc+1 (wraps modulo 2^PC_W); redirect<=0.

Branch targets:
- nonbranch = ex_pc+1.
- branch = nonbranch + (br_imm >>> 2), with br_imm sign-extended or truncated to PC_W. All arithmetic wraps.

npc by br_op:
- EQ: os==ot.
- NE: os!=ot.
- LT: os<ot.
- LE: os<=ot.
- JR: npc=br_os[PC_W-1:0] unconditionally.
- Otherwise: nonbranch.
- Signedness of LT/LE follows SIGNED_CMP.

Countdown (evaluated in every non-stalled, non-halted cycle, independently of the PC selection):
- If br_issue=1, count<=BR_LAT. This covers br_issue in the same cycle as resolve: the resolve completes and the counter reloads.
- Else if count>0, count<=count-1.
- A jmp_valid coinciding with resolve takes priority; the branch result is discarded and count still decrements to 0.
- count width is 3 bits.

Other rules:
- br_pending = (count!=0).
- halt_req while count>1 is still honoured, and the pending branch is dropped.
- Latency: every load is visible on pc_out one cycle after the edge; no combinational path from inputs to pc_out.

Optional Feature:
- Macro PC_SEQ_PERF_EN.
- Defined: perf_redirects increments on every cycle redirect is set; perf_stalls increments on every stalled, non-halted cycle. Both are 32-bit, saturate at 0xFFFFFFFF, and clear only on rst.
- Undefined: no counter flops; both ports are tied to 0.

Decomposition:
- Shared package pc_seq_pkg holds:
  - br_op encodings BR_EQ=3'd0, BR_NE=3'd1, BR_LT=3'd2, BR_LE=3'd3, BR_JR=3'd4;
  - the count width constant.
- One combinational sub-module, pc_seq_npc, computes branch/nonbranch/npc from br_op, operands, imm, ex_pc and SIGNED_CMP. The top level holds all state.

Test Plan:
- Sequential and reset: rst for 2 cycles, then release; run 5 cycles -> pc_out 0,1,2,3,4; redirect stays 0. Assert rst mid-run -> pc_out=0 immediately.
- Jump: jmp_valid with jmp_addr=0x100 -> next cycle pc_out=0x40, redirect=1 for one cycle, then 0x41.
- Branch taken with BR_LAT=2: br_issue, then 2 cycles later br_op=EQ, os=ot=5, ex_pc=0x10, imm=0x20 -> pc_out=0x19, redirect=1. Repeat with os=5, ot=6 -> pc_out=0x11, redirect=0.
- Signed compare with SIGNED_CMP=1: LT, os=0xFFFFFFFF, ot=1 -> taken. With SIGNED_CMP=0 -> not taken. JR with os=0x1234 -> pc_out=0x1234.
- Collisions:
  - jmp_valid on the resolve cycle -> jump target wins.
  - br_issue on the resolve cycle -> br_pending remains 1 for another BR_LAT cycles.
  - stall during countdown -> resolve is delayed by the stall length.
- Halt and perf: halt_req with ex_pc=0x22 -> pc_out=0x22, halted=1, frozen under further jumps and branches. With PC_SEQ_PERF_EN, after 3 stalls and 2 redirects -> perf_stalls=3, perf_redirects=2.
